// File: rtl/mix_columns_seq_pkg.sv
// rtl/mix_columns_seq_pkg.sv - shared constants, FSM encoding and GF(2^8) xtime for mix_columns_seq
package mix_columns_seq_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         COL_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// rtl/mix_column_word.sv - combinational single-column MixColumns (inverse mode under MIX_COLUMNS_INV_EN)
module mix_column_word
  import mix_columns_seq_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic             inv,
`endif
  output logic [COL_W-1:0] col_out
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
`ifdef MIX_COLUMNS_INV_EN
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
`endif

  // Per-byte products, then the circulant row sums
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = col_in[8*i +: 8];
      x2[i] = xtime(a[i]);
    end
    col_out[7:0]   = x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3];
    col_out[15:8]  = a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3];
    col_out[23:16] = a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3];
    col_out[31:24] = x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3];
`ifdef MIX_COLUMNS_INV_EN
    for (int i = 0; i < 4; i++) begin
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    if (inv) begin
      col_out[7:0]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      col_out[15:8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      col_out[23:16] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      col_out[31:24] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
`endif
  end

endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential one-column-per-cycle MixColumns engine (inverse mode under MIX_COLUMNS_INV_EN)
module mix_columns_seq
  import mix_columns_seq_pkg::*;
#(
  parameter int NUM_COLS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_COLS*COL_W-1:0] data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_COLS*COL_W-1:0] data_out
`ifdef MIX_COLUMNS_INV_EN
  ,
  input  logic                      inv
`endif
);

  localparam int CNT_W = $clog2(NUM_COLS);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [NUM_COLS*COL_W-1:0] work;
  logic [NUM_COLS*COL_W-1:0] result;
  logic [COL_W-1:0]          col_mixed;
  logic                      load, mix_en;
`ifdef MIX_COLUMNS_INV_EN
  logic                      inv_q;
`endif

  assign data_out = result;

  // Single shared column mixer, fed the column selected by the counter
  mix_column_word u_mix (
    .col_in  (work[cnt*COL_W +: COL_W]),
`ifdef MIX_COLUMNS_INV_EN
    .inv     (inv_q),
`endif
    .col_out (col_mixed)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    mix_en    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        mix_en = 1'b1;
        if (cnt == LAST_COL) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working copy, column counter and result slots; counter wraps to 0 on the last column
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work   <= '0;
      result <= '0;
      cnt    <= '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q  <= 1'b0;
`endif
    end else if (load) begin
      work  <= data_in;
      cnt   <= '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q <= inv;
`endif
    end else if (mix_en) begin
      result[cnt*COL_W +: COL_W] <= col_mixed;
      cnt                        <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - randomized self-checking bench for mix_columns_seq against a GF(2^8) matrix model
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         inv_i;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] FIPS_IN  = {32'hd5d4d4d4, 32'hc6c6c6c6, 32'h5c220af2, 32'h455313db};
  localparam logic [127:0] FIPS_OUT = {32'hd6d7d5d5, 32'hc6c6c6c6, 32'h9d58dc9f, 32'hbca14d8e};
  localparam logic [127:0] ONES_IN  = {16{8'h01}};

  mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef MIX_COLUMNS_INV_EN
    ,
    .inv       (inv_i)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Polynomial product reduced by 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (y[i]) p = p ^ (16'(x) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  // First row of the (inverse) MixColumns circulant; row r is this row rotated right by r
  function automatic logic [7:0] coef(input logic iv, input int idx);
    case (idx)
      0: return iv ? 8'h0e : 8'h02;
      1: return iv ? 8'h0b : 8'h03;
      2: return iv ? 8'h0d : 8'h01;
      default: return iv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic iv);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef(iv, (k - r + 4) % 4), s[32*c + 8*k +: 8]);
        o[32*c + 8*r +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a state in IDLE, accept it, and wait (out_ready low) until out_valid; lat = edges after acceptance edge
  task automatic run_op(input logic [127:0] d, input logic iv, input bit garbage, output int lat);
    in_valid = 1'b1;
    data_in  = d;
    inv_i    = iv;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        data_in  = rand128();
        inv_i    = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_out_valid", 128'(out_valid), 128'(0));
    check("post_hs_in_ready", 128'(in_ready), 128'(1));
  endtask

  int           lat;
  logic [127:0] held;
  int           seen;
  logic [127:0] exp_q[$];
  int           done_cnt;
  bit           acc;
  int           acc_cyc[$];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; inv_i = 1'b0;
    tick(); tick();
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_data_out", data_out, 128'(0));
    rst_n = 1'b1;
    tick();

    // Known-answer vector: load edge plus four column edges, so valid shows four edges after acceptance
    run_op(FIPS_IN, 1'b0, 1'b0, lat);
    check("fips_latency", 128'(lat), 128'(4));
    check("fips_const", data_out, FIPS_OUT);
    check("fips_model", data_out, mix_ref(FIPS_IN, 1'b0));
    handshake();

    // Backpressure: ten stalled cycles in DONE
    data_in = rand128();
    held = data_in;
    run_op(held, 1'b0, 1'b0, lat);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (data_out !== mix_ref(held, 1'b0) || !out_valid || in_ready) seen++;
      tick();
    end
    check("stall_stable", 128'(seen), 128'(0));
    check("stall_result", data_out, mix_ref(held, 1'b0));
    handshake();
    run_op(ONES_IN, 1'b0, 1'b0, lat);
    check("after_stall_accept_latency", 128'(lat), 128'(4));
    handshake();

    // Reset during the second BUSY cycle
    in_valid = 1'b1;
    data_in  = rand128();
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_data_out", data_out, 128'(0));
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("midrst_no_valid", 128'(seen), 128'(0));
    run_op(ONES_IN, 1'b0, 1'b0, lat);
    check("ones_result", data_out, ONES_IN);
    handshake();

    // Garbage on the input side while busy must not disturb the result
    run_op(FIPS_IN, 1'b0, 1'b1, lat);
    check("garbage_latency", 128'(lat), 128'(4));
    check("garbage_result", data_out, FIPS_OUT);
    handshake();

`ifdef MIX_COLUMNS_INV_EN
    run_op(FIPS_OUT, 1'b1, 1'b0, lat);
    check("inv_latency", 128'(lat), 128'(4));
    check("inv_recover", data_out, FIPS_IN);
    handshake();
    run_op(FIPS_IN, 1'b0, 1'b0, lat);
    check("inv0_forward", data_out, FIPS_OUT);
    handshake();
`endif

    // Back-to-back acceptance spacing with out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inv_i     = 1'b0;
    acc_cyc.delete();
    for (int cyc = 0; cyc < 40 && acc_cyc.size() < 4; cyc++) begin
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        data_in = rand128();
      end
      tick();
    end
    in_valid = 1'b0;
    check("spacing_count", 128'(acc_cyc.size()), 128'(4));
    for (int i = 1; i < acc_cyc.size(); i++)
      check("spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(6));
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;

    // Random traffic with random backpressure against a FIFO of model results
    exp_q.delete();
    done_cnt = 0;
    for (int cyc = 0; cyc < 3000 && done_cnt < 30; cyc++) begin
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        data_in  = rand128();
`ifdef MIX_COLUMNS_INV_EN
        inv_i    = 1'($urandom_range(0, 1));
`else
        inv_i    = 1'b0;
`endif
      end
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(mix_ref(data_in, inv_i));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rand_unexpected_output", data_out, 128'(0) ^ ~data_out);
        else check("rand_result", data_out, exp_q.pop_front());
        done_cnt++;
      end
      tick();
      if (acc) in_valid = 1'b0;
    end
    check("rand_completed", 128'(done_cnt), 128'(30));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
